flop_skid: RTL and testbench



---
 rtl/flop_skid_if.sv | 51 +++++
 rtl/flop_skid.sv | 82 ++++++++
 tb/tb_flop_skid.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/flop_skid_if.sv
// flop_skid_if: handshake bundle for the flop_skid elastic register.
//
// Handshake rules: a word moves on a rising clk edge when valid and ready
// are both high on that side. The producer holds input_d steady while
// in_valid is high and in_ready is low. The block holds output_q steady
// while out_valid is high and out_ready is low. ready never depends
// combinationally on valid on either side.
//
// Signals:
//   input_d   producer -> block  write-side data word
//   in_valid  producer -> block  input_d carries a word
//   in_ready  block -> producer  block accepts a word this cycle
//   output_q  block -> consumer  read-side data word
//   out_valid block -> consumer  output_q carries a word
//   out_ready consumer -> block  consumer takes output_q this cycle
//   count     block -> observer  words held (0, 1 or 2), also the FSM state
//
// Modports:
//   slave  - the flop_skid block itself
//   master - the environment (producer + consumer) driving the block
interface flop_skid_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] input_d;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] output_q;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       count;

    modport slave (
        input  input_d,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output output_q,
        output out_valid,
        output count
    );

    modport master (
        output input_d,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  output_q,
        input  out_valid,
        input  count
    );
endinterface

// File: rtl/flop_skid.sv
// flop_skid: elastic pipeline register with a two-entry skid buffer.
//
// Accepts one word per cycle, presents it one cycle later, and absorbs a
// single consumer stall. in_ready and out_valid are decoded only from the
// registered state, so there is no combinational path from out_ready to
// in_ready nor from in_valid to out_valid.
//
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset; clears state and both data regs
//   bus   flop_skid_if.slave handshake bundle (see flop_skid_if.sv)
module flop_skid #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    flop_skid_if.slave     bus
);
    // State value equals the number of words held and is exported as count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;
    logic             in_ready;
    logic             out_valid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= bus.input_d;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= bus.input_d;
                    end else if (in_fire) begin
                        // Consumer stalled: park the new word behind main.
                        skid_q <= bus.input_d;
                        state  <= FULL;
                    end else if (out_fire) begin
                        // main keeps the departed word; out_valid qualifies it.
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.output_q  = main_q;
    assign bus.count     = state;
endmodule

// File: tb/tb_flop_skid.sv
module tb_flop_skid;
    localparam int WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    flop_skid_if #(.WIDTH(WIDTH)) bus ();

    flop_skid #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic             in_valid;
        logic [WIDTH-1:0] input_d;
        logic             out_ready;
        logic [1:0]       exp_count;
        logic             exp_out_valid;
        logic             exp_in_ready;
        logic [WIDTH-1:0] exp_q;
        string            name;
    } vec_t;

    vec_t vecs[$];

    int n_total;
    int n_pass;

    // Expected values: state after the edge that consumes these inputs.
    function automatic void add_vec(input logic iv, input logic [WIDTH-1:0] d,
                                    input logic ordy, input logic [1:0] cnt,
                                    input logic [WIDTH-1:0] q, input string name);
        vec_t v;
        v.in_valid      = iv;
        v.input_d       = d;
        v.out_ready     = ordy;
        v.exp_count     = cnt;
        v.exp_out_valid = (cnt != 2'd0);
        v.exp_in_ready  = (cnt != 2'd2);
        v.exp_q         = q;
        v.name          = name;
        vecs.push_back(v);
    endfunction

    // ---------------- scoreboard helpers ----------------
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [1:0] cnt,
                              input logic [WIDTH-1:0] q);
        check({name, ".count"},     32'(bus.count),     32'(cnt));
        check({name, ".out_valid"}, 32'(bus.out_valid), 32'(cnt != 2'd0));
        check({name, ".in_ready"},  32'(bus.in_ready),  32'(cnt != 2'd2));
        check({name, ".output_q"},  32'(bus.output_q),  32'(q));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        bus.in_valid  = iv;
        bus.input_d   = d;
        bus.out_ready = ordy;
    endtask

    // Apply inputs, let one rising edge consume them, sample 1 time unit later.
    task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        drive(iv, d, ordy);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        // Streaming 0x01..0x10 with out_ready held high.
        for (int i = 1; i <= 16; i++) begin
            add_vec(1'b1, 8'(i), 1'b1, 2'd1, 8'(i), $sformatf("stream_%0d", i));
        end
        add_vec(1'b0, 8'h00, 1'b1, 2'd0, 8'h10, "stream_drain");
        // Stall absorb: A1, A2 accepted, A3 held by producer, then drain in order.
        add_vec(1'b1, 8'hA1, 1'b0, 2'd1, 8'hA1, "stall_a1");
        add_vec(1'b1, 8'hA2, 1'b0, 2'd2, 8'hA1, "stall_a2");
        add_vec(1'b1, 8'hA3, 1'b0, 2'd2, 8'hA1, "stall_a3_blocked");
        add_vec(1'b1, 8'hA3, 1'b1, 2'd1, 8'hA2, "stall_pop_a1");
        add_vec(1'b1, 8'hA3, 1'b1, 2'd1, 8'hA3, "stall_a3_in");
        add_vec(1'b0, 8'h00, 1'b1, 2'd0, 8'hA3, "stall_pop_a3");
        // Hold stability: 0x3C stays put while input_d toggles.
        add_vec(1'b1, 8'h3C, 1'b0, 2'd1, 8'h3C, "hold_load");
        for (int i = 0; i < 5; i++) begin
            add_vec(1'b0, (i % 2 == 0) ? 8'hFF : 8'h00, 1'b0, 2'd1, 8'h3C,
                    $sformatf("hold_%0d", i));
        end
        add_vec(1'b0, 8'h00, 1'b1, 2'd0, 8'h3C, "hold_pop");
        // Drain to empty: 0x77 in, out, then idle with out_ready high.
        add_vec(1'b1, 8'h77, 1'b1, 2'd1, 8'h77, "drain_load");
        add_vec(1'b0, 8'h00, 1'b1, 2'd0, 8'h77, "drain_pop");
        add_vec(1'b0, 8'hEE, 1'b1, 2'd0, 8'h77, "drain_idle0");
        add_vec(1'b0, 8'hEE, 1'b1, 2'd0, 8'h77, "drain_idle1");
        // Fill to FULL ahead of the mid-stream reset.
        add_vec(1'b1, 8'h11, 1'b0, 2'd1, 8'h11, "prefill_0");
        add_vec(1'b1, 8'h22, 1'b0, 2'd2, 8'h11, "prefill_1");

        // Power-on reset, checked before release.
        repeat (2) @(posedge clk);
        #1;
        check_outs("por", 2'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in_valid, vecs[i].input_d, vecs[i].out_ready);
            check({vecs[i].name, ".count"},     32'(bus.count),     32'(vecs[i].exp_count));
            check({vecs[i].name, ".out_valid"}, 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
            check({vecs[i].name, ".in_ready"},  32'(bus.in_ready),  32'(vecs[i].exp_in_ready));
            check({vecs[i].name, ".output_q"},  32'(bus.output_q),  32'(vecs[i].exp_q));
        end

        // Mid-stream asynchronous reset while FULL, observed between edges.
        drive(1'b1, 8'h33, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 2'd0, 8'h00);
        @(posedge clk);
        #1;
        check_outs("reset_held", 2'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h5A, 1'b1);
        check_outs("post_reset_5a", 2'd1, 8'h5A);
        step(1'b0, 8'h00, 1'b1);
        check_outs("post_reset_alone", 2'd0, 8'h5A);
        step(1'b0, 8'h00, 1'b1);
        check_outs("post_reset_idle", 2'd0, 8'h5A);

        // Random handshake against a reference queue model.
        exp_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic             iv;
            logic             ordy;
            logic [WIDTH-1:0] d;
            logic             m_ready;
            logic             m_valid;
            m_ready = (exp_q.size() < 2);
            m_valid = (exp_q.size() != 0);
            check("rand.count", 32'(bus.count), 32'(exp_q.size()));
            check("rand.in_ready", 32'(bus.in_ready), 32'(m_ready));
            check("rand.out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                check("rand.output_q", 32'(bus.output_q), 32'(exp_q[0]));
            end
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            d    = 8'($urandom_range(0, 255));
            if (m_valid && ordy) begin
                void'(exp_q.pop_front());
            end
            if (iv && m_ready) begin
                exp_q.push_back(d);
            end
            step(iv, d, ordy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
